// File: rtl/bet_entry.sv
// Bet entry: edits bet amount, step size and pick mask during the bet-input state,
// validates the bet on confirm and freezes it until the next round.
module bet_entry #(
  parameter logic [3:0]  S_BET_INPUT = 4'd1,
  parameter logic [15:0] DEFAULT_BET = 16'd10,
  parameter logic [15:0] MIN_BET     = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic [15:0] current_money,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_step,
  input  logic [3:0]  btn_pick,
  input  logic        btn_confirm,
  output logic [15:0] bet_amount,
  output logic [2:0]  bet_count,
  output logic [3:0]  bet_mask,
  output logic [6:0]  step_size,
  output logic [1:0]  phase,
  output logic        bet_valid,
  output logic        bet_error
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_AMOUNT = 2'd1,
    PH_PICK   = 2'd2,
    PH_LOCKED = 2'd3
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [15:0] amount_q, amount_d;
  logic [3:0]  mask_q, mask_d;
  logic [6:0]  step_q, step_d;
  logic [3:0]  prev_state_q, prev_state_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  logic        entry;
  logic        in_bet_state;
  logic        up_xor_down;
  logic [16:0] up_sum;
  logic [16:0] down_thresh;
  logic [15:0] entry_base;
  logic [15:0] amount_edit;
  logic [2:0]  count;

  assign in_bet_state = (state == S_BET_INPUT);
  assign entry        = in_bet_state && (prev_state_q != S_BET_INPUT);
  assign up_xor_down  = btn_up ^ btn_down;
  assign up_sum       = {1'b0, amount_q} + {10'b0, step_q};
  // Amount must stay above step+MIN_BET-1 for a plain subtraction; otherwise floor at MIN_BET.
  assign down_thresh  = {10'b0, step_q} + {1'b0, MIN_BET} - 17'd1;
  assign entry_base   = (amount_q == '0) ? DEFAULT_BET : amount_q;
  assign count        = {2'b0, mask_q[0]} + {2'b0, mask_q[1]}
                      + {2'b0, mask_q[2]} + {2'b0, mask_q[3]};

  always_comb begin
    phase_d      = phase_q;
    amount_d     = amount_q;
    mask_d       = mask_q;
    step_d       = step_q;
    prev_state_d = state;
    valid_d      = 1'b0;
    error_d      = 1'b0;
    amount_edit  = amount_q;

    if (entry) begin
      phase_d  = PH_AMOUNT;
      amount_d = (entry_base > current_money) ? current_money : entry_base;
      mask_d   = '0;
      step_d   = 7'd1;
    end else if ((phase_q == PH_AMOUNT || phase_q == PH_PICK) && !in_bet_state) begin
      phase_d = PH_IDLE;
      mask_d  = '0;
    end else begin
      unique case (phase_q)
        PH_AMOUNT: begin
          if (btn_confirm) begin
            if (current_money == '0) error_d = 1'b1;
            else                     phase_d = PH_PICK;
          end else if (up_xor_down) begin
            if (btn_up)
              amount_edit = (up_sum > {1'b0, current_money}) ? current_money : up_sum[15:0];
            else if ({1'b0, amount_q} > down_thresh)
              amount_edit = amount_q - {9'b0, step_q};
            else
              amount_edit = MIN_BET;
          end else if (btn_step) begin
            unique case (step_q)
              7'd1:    step_d = 7'd10;
              7'd10:   step_d = 7'd100;
              default: step_d = 7'd1;
            endcase
          end
          amount_d = (amount_edit > current_money) ? current_money : amount_edit;
        end
        PH_PICK: begin
          // up/down/step do nothing here but still outrank pick in the same cycle.
          if (btn_confirm) begin
            if (count == 3'd0) begin
              error_d = 1'b1;
            end else begin
              phase_d = PH_LOCKED;
              valid_d = 1'b1;
            end
          end else if (!up_xor_down && !btn_step) begin
            mask_d = mask_q ^ btn_pick;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= PH_IDLE;
      amount_q     <= '0;
      mask_q       <= '0;
      step_q       <= 7'd1;
      prev_state_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      amount_q     <= amount_d;
      mask_q       <= mask_d;
      step_q       <= step_d;
      prev_state_q <= prev_state_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign bet_amount = amount_q;
  assign bet_mask   = mask_q;
  assign bet_count  = count;
  assign step_size  = step_q;
  assign phase      = phase_q;
  assign bet_valid  = valid_q;
  assign bet_error  = error_q;

endmodule
